// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//
// Receive control unit for the UART RX path. Sequences the receive datapath:
// it takes the start-bit flag from the start-bit detector, qualifies the
// start bit at mid-bit, emits one shift strobe per data bit at the middle of
// each bit period, checks the stop bit and commands the RX buffer load.
// Holds the bit-period timer, the data-bit counter and the receive FSM.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (even, >= 4)
//   DATA_BITS     data bits per frame (1..16)
//
// Ports:
//   clk                  in   system clock, all state on rising edge
//   rst                  in   asynchronous active-high reset
//   new_packet_detected  in   1-cycle falling-edge flag from start detector
//   serial_in            in   synchronized serial line, idle = 1
//   shift_strobe         out  1-cycle pulse, shift register captures serial_in
//   load_buffer          out  1-cycle pulse, RX buffer loads shift register
//   framing_error        out  sticky, stop bit sampled as 0
//   parity_error         out  sticky, even-parity mismatch
//   busy                 out  high whenever the FSM is not idle
//
// Optional feature:
//   UART_RX_PARITY_CHECK_EN  when defined, a PARITY bit period sits between
//                            the last data bit and the stop bit and even
//                            parity is checked; when undefined parity_error
//                            is tied low.
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic new_packet_detected,
  input  logic serial_in,
  output logic shift_strobe,
  output logic load_buffer,
  output logic framing_error,
  output logic parity_error,
  output logic busy
);

  localparam int HALF    = CLKS_PER_BIT / 2;
  localparam int TIMER_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W   = $clog2(DATA_BITS + 1);

  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(HALF - 1);
  localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_CHK = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_CHECK_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    LOAD      = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               framing_error_q, framing_error_d;
  logic               timer_event;

`ifdef UART_RX_PARITY_CHECK_EN
  logic               parity_acc_q, parity_acc_d;
  logic               parity_error_q, parity_error_d;
`endif

  // The start check samples half a bit after the falling edge; every other
  // timed state waits a full bit period so sampling stays at mid-bit.
  always_comb begin
    if (state_q == START_CHK) begin
      timer_event = (timer_q == HALF_LAST);
    end else begin
      timer_event = (timer_q == BIT_LAST);
    end
  end

  // State, timer, bit counter and sticky flags. Async reset aborts any frame
  // in progress, so no load can follow a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      bit_cnt_q       <= '0;
      framing_error_q <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
      parity_acc_q    <= 1'b0;
      parity_error_q  <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      bit_cnt_q       <= bit_cnt_d;
      framing_error_q <= framing_error_d;
`ifdef UART_RX_PARITY_CHECK_EN
      parity_acc_q    <= parity_acc_d;
      parity_error_q  <= parity_error_d;
`endif
    end
  end

  // Next-state logic. Every state change happens either from IDLE/LOAD
  // (timer already 0) or on a timer event (timer wrapping to 0), so the
  // timer is zero on entry to each state.
  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q + TIMER_ONE;
    bit_cnt_d       = bit_cnt_q;
    framing_error_d = framing_error_q;
`ifdef UART_RX_PARITY_CHECK_EN
    parity_acc_d    = parity_acc_q;
    parity_error_d  = parity_error_q;
`endif

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (new_packet_detected) begin
          state_d = START_CHK;
        end
      end

      START_CHK: begin
        if (timer_event) begin
          timer_d = '0;
          if (!serial_in) begin
            // A start bit still low at mid-bit is genuine: begin a fresh
            // frame and drop the error flags of the previous one.
            state_d         = DATA;
            bit_cnt_d       = '0;
            framing_error_d = 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
            parity_acc_d    = 1'b0;
            parity_error_d  = 1'b0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (timer_event) begin
          timer_d   = '0;
          bit_cnt_d = bit_cnt_q + CNT_ONE;
`ifdef UART_RX_PARITY_CHECK_EN
          parity_acc_d = parity_acc_q ^ serial_in;
`endif
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_CHECK_EN
      PARITY: begin
        if (timer_event) begin
          timer_d = '0;
          // Even parity: data bits plus parity bit must XOR to zero. The
          // frame continues either way so the data is still delivered.
          if (parity_acc_q ^ serial_in) begin
            parity_error_d = 1'b1;
          end
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        if (timer_event) begin
          timer_d = '0;
          if (serial_in) begin
            state_d = LOAD;
          end else begin
            framing_error_d = 1'b1;
            state_d         = IDLE;
          end
        end
      end

      LOAD: begin
        timer_d = '0;
        state_d = IDLE;
      end

      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Strobes decode registered state only, so they are glitch-free and can
  // never coincide (DATA and LOAD are distinct states).
  assign shift_strobe  = (state_q == DATA) && (timer_q == BIT_LAST);
  assign load_buffer   = (state_q == LOAD);
  assign busy          = (state_q != IDLE);
  assign framing_error = framing_error_q;

`ifdef UART_RX_PARITY_CHECK_EN
  assign parity_error  = parity_error_q;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Self-checking bench for uart_rx_ctrl. Frames are described by data, parity
// bit, stop bit, optional start glitch and optional mid-frame reset. The
// reference model derives expected outputs for each cycle from bit-period
// arithmetic (mid-bit sample points relative to the detect cycle).
// Cycle 0 of each frame is the cycle in which new_packet_detected is high.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

  localparam int CPB  = 10;
  localparam int DB   = 8;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_CHECK_EN
  localparam int PAR  = 1;
`else
  localparam int PAR  = 0;
`endif
  localparam int MAXC = 400;
  localparam logic [15:0] DATA_MASK = 16'((32'd1 << DB) - 1);

  logic clk = 1'b0;
  logic rst;
  logic new_packet_detected;
  logic serial_in;
  logic shift_strobe;
  logic load_buffer;
  logic framing_error;
  logic parity_error;
  logic busy;

  uart_rx_ctrl #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .new_packet_detected (new_packet_detected),
    .serial_in           (serial_in),
    .shift_strobe        (shift_strobe),
    .load_buffer         (load_buffer),
    .framing_error       (framing_error),
    .parity_error        (parity_error),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Current frame description
  logic [15:0] cur_data;
  bit          cur_par;
  bit          cur_stop;
  int          cur_glitch;
  int          cur_rst_at;
  bit          extra_det [0:MAXC-1];

  // Per-cycle observations: {shift_strobe, load_buffer, busy, ferr, perr}
  logic [4:0]  obs      [0:MAXC-1];
  bit          line_log [0:MAXC-1];

  // Flag values the model carries from one frame to the next
  bit model_ferr;
  bit model_perr;

  // Serial line level for frame cycle c: start bit, data LSB first,
  // optional parity bit, stop bit, then idle.
  function automatic bit line_at(int c);
    int k;
    if (c < 0) return 1'b1;
    if (cur_glitch > 0 && c >= cur_glitch) return 1'b1;
    if (c < CPB) return 1'b0;
    k = c / CPB - 1;
    if (k < DB) return cur_data[k];
    k = k - DB;
    if (PAR == 1) begin
      if (k == 0) return cur_par;
      k = k - 1;
    end
    if (k == 0) return cur_stop;
    return 1'b1;
  endfunction

  // Expected {strobe, load, busy, ferr, perr} in frame cycle c.
  function automatic logic [4:0] model_outputs(int c);
    bit valid;
    bit strobe, load, bsy, ferr, perr;
    int stopchk;
    int parchk;
    if (cur_rst_at >= 0 && c >= cur_rst_at) return 5'b0;
    valid   = (line_at(HALF) == 1'b0);
    stopchk = HALF + CPB * (DB + 1 + PAR);
    parchk  = HALF + CPB * (DB + 1);
    ferr    = model_ferr;
    perr    = model_perr;
    strobe  = 1'b0;
    load    = 1'b0;
    if (!valid) begin
      bsy = (c >= 1 && c <= HALF);
    end else begin
      strobe = (c >= HALF + CPB) && (c <= HALF + CPB * DB) &&
               (((c - HALF) % CPB) == 0);
      bsy    = (c >= 1) && (c <= (cur_stop ? stopchk + 1 : stopchk));
      load   = cur_stop && (c == stopchk + 1);
      if (c >= HALF + 1) begin
        ferr = 1'b0;
        perr = 1'b0;
      end
      if (!cur_stop && c >= stopchk + 1) ferr = 1'b1;
      if (PAR == 1 && ((^(cur_data & DATA_MASK)) ^ cur_par) && c >= parchk + 1)
        perr = 1'b1;
    end
    return {strobe, load, bsy, ferr, perr};
  endfunction

  task automatic setup_frame(input logic [15:0] data, input bit par,
                             input bit stop, input int glitch, input int rst_at);
    cur_data   = data & DATA_MASK;
    cur_par    = par;
    cur_stop   = stop;
    cur_glitch = glitch;
    cur_rst_at = rst_at;
    for (int i = 0; i < MAXC; i++) extra_det[i] = 1'b0;
  endtask

  // Drives one frame for ncycles cycles and logs outputs at each negedge.
  task automatic drive_frame(input int ncycles);
    for (int c = 0; c < ncycles; c++) begin
      @(posedge clk);
      #1;
      new_packet_detected = (c == 0) || extra_det[c];
      serial_in           = line_at(c);
      rst                 = (c == cur_rst_at);
      @(negedge clk);
      obs[c]      = {shift_strobe, load_buffer, busy, framing_error, parity_error};
      line_log[c] = serial_in;
    end
  endtask

  task automatic end_frame();
    logic [4:0] fin;
    fin        = model_outputs(MAXC - 1);
    model_ferr = fin[1];
    model_perr = fin[0];
  endtask

  task automatic test_reset();
    rst                 = 1'b1;
    new_packet_detected = 1'b0;
    serial_in           = 1'b1;
    model_ferr          = 1'b0;
    model_perr          = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({shift_strobe, load_buffer, busy, framing_error, parity_error} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got %b, expected 00000",
               {shift_strobe, load_buffer, busy, framing_error, parity_error});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      n_checks++;
      if ({shift_strobe, load_buffer, busy, framing_error, parity_error} !== 5'b0) begin
        n_fail++;
        $display("[TB] FAIL idle_line cycle %0d: got %b, expected 00000", c,
                 {shift_strobe, load_buffer, busy, framing_error, parity_error});
      end
    end
  endtask

  task automatic test_valid_frame(input logic [15:0] data);
    int n;
    int k;
    logic [4:0]  exp;
    logic [15:0] recon;
    setup_frame(data, ^(data & DATA_MASK), 1'b1, 0, -1);
    n = HALF + CPB * (DB + 1 + PAR) + 5;
    drive_frame(n);
    for (int c = 0; c < n; c++) begin
      exp = model_outputs(c);
      n_checks++;
      if (obs[c] !== exp) begin
        n_fail++;
        $display("[TB] FAIL valid_frame cycle %0d: got strb/load/busy/ferr/perr=%b, expected %b",
                 c, obs[c], exp);
      end
    end
    recon = '0;
    k     = 0;
    for (int c = 0; c < n; c++) begin
      if (obs[c][4]) begin
        if (k < 16) recon[k] = line_log[c];
        k++;
      end
    end
    n_checks++;
    if (recon !== cur_data || k != DB) begin
      n_fail++;
      $display("[TB] FAIL valid_frame_data: got 0x%0h in %0d strobes, expected 0x%0h in %0d",
               recon, k, cur_data, DB);
    end
    end_frame();
  endtask

  task automatic test_glitch_start();
    int n;
    logic [4:0] exp;
    setup_frame(16'h00FF, 1'b0, 1'b1, 3, -1);
    n = 20;
    drive_frame(n);
    for (int c = 0; c < n; c++) begin
      exp = model_outputs(c);
      n_checks++;
      if (obs[c] !== exp) begin
        n_fail++;
        $display("[TB] FAIL glitch_start cycle %0d: got %b, expected %b", c, obs[c], exp);
      end
    end
    end_frame();
  endtask

  task automatic test_bad_stop();
    int n;
    logic [4:0] exp;
    setup_frame(16'h003C, 1'b0, 1'b0, 0, -1);
    n = HALF + CPB * (DB + 1 + PAR) + 5;
    drive_frame(n);
    for (int c = 0; c < n; c++) begin
      exp = model_outputs(c);
      n_checks++;
      if (obs[c] !== exp) begin
        n_fail++;
        $display("[TB] FAIL bad_stop cycle %0d: got %b, expected %b", c, obs[c], exp);
      end
    end
    end_frame();
  endtask

  task automatic test_reset_mid_frame();
    int n;
    logic [4:0] exp;
    setup_frame(16'h0096, 1'b0, 1'b1, 0, 40);
    n = 120;
    drive_frame(n);
    for (int c = 0; c < n; c++) begin
      exp = model_outputs(c);
      n_checks++;
      if (obs[c] !== exp) begin
        n_fail++;
        $display("[TB] FAIL reset_mid_frame cycle %0d: got %b, expected %b", c, obs[c], exp);
      end
    end
    end_frame();
  endtask

  // Random frames back to back with stray detect pulses while busy.
  task automatic test_back_to_back();
    int n;
    int stopchk;
    logic [4:0] exp;
    stopchk = HALF + CPB * (DB + 1 + PAR);
    for (int f = 0; f < 6; f++) begin
      setup_frame(16'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 4) != 0), 0, -1);
      for (int j = 0; j < 3; j++) extra_det[$urandom_range(1, stopchk)] = 1'b1;
      n = (cur_stop ? stopchk + 2 : stopchk + 1) + int'($urandom_range(0, 2));
      drive_frame(n);
      for (int c = 0; c < n; c++) begin
        exp = model_outputs(c);
        n_checks++;
        if (obs[c] !== exp) begin
          n_fail++;
          $display("[TB] FAIL back_to_back frame %0d cycle %0d: got %b, expected %b",
                   f, c, obs[c], exp);
        end
      end
      end_frame();
    end
  endtask

`ifdef UART_RX_PARITY_CHECK_EN
  task automatic test_parity(input bit par, input bit exp_perr);
    int n;
    int load_c;
    logic [4:0] exp;
    setup_frame(16'h0007, par, 1'b1, 0, -1);
    load_c = HALF + CPB * (DB + 2) + 1;
    n = load_c + 4;
    drive_frame(n);
    for (int c = 0; c < n; c++) begin
      exp = model_outputs(c);
      n_checks++;
      if (obs[c] !== exp) begin
        n_fail++;
        $display("[TB] FAIL parity cycle %0d: got %b, expected %b", c, obs[c], exp);
      end
    end
    n_checks++;
    if (obs[load_c][3] !== 1'b1 || obs[load_c + 1][0] !== exp_perr) begin
      n_fail++;
      $display("[TB] FAIL parity_load: got load=%b perr=%b, expected load=1 perr=%b",
               obs[load_c][3], obs[load_c + 1][0], exp_perr);
    end
    end_frame();
  endtask
`endif

  initial begin
    $display("[TB] uart_rx_ctrl bench start");
    test_reset();
    test_valid_frame(16'h00A5);
    test_glitch_start();
    test_bad_stop();
    test_valid_frame(16'h005A);
    test_reset_mid_frame();
    test_valid_frame(16'h00C3);
    test_back_to_back();
`ifdef UART_RX_PARITY_CHECK_EN
    test_parity(1'b0, 1'b1);
    test_parity(1'b1, 1'b0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
